// File: rtl/particle_broadcast_ctrl_pkg.sv
// Shared definitions for the particle broadcast sequencer: default widths,
// read latency and the FSM state encoding.
package particle_broadcast_ctrl_pkg;

    localparam int PBC_ID_WIDTH   = 7;
    localparam int PBC_RD_LATENCY = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WAIT_NUM  = 3'd1;
    localparam state_t ST_BROADCAST = 3'd2;
    localparam state_t ST_DRAIN     = 3'd3;
    localparam state_t ST_DONE      = 3'd4;

endpackage

// File: rtl/particle_broadcast_ctrl_delay.sv
// Fixed-depth {id, valid} shift register that aligns the issued particle ID
// with the particle-cache read data.
module particle_id_delay #(
    parameter int ID_W    = 7,
    parameter int LATENCY = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ID_W-1:0] i_id,
    input  logic            i_valid,
    output logic [ID_W-1:0] o_id,
    output logic            o_valid
);

    logic [ID_W-1:0]    r_id [LATENCY];
    logic [LATENCY-1:0] r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_id[i]    <= '0;
                r_valid[i] <= 1'b0;
            end
        end else begin
            r_id[0]    <= i_id;
            r_valid[0] <= i_valid;
            for (int i = 1; i < LATENCY; i++) begin
                r_id[i]    <= r_id[i-1];
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    assign o_id    = r_id[LATENCY-1];
    assign o_valid = r_valid[LATENCY-1];

endmodule

// File: rtl/particle_broadcast_ctrl.sv
// Sweeps every (reference, neighbour) particle pair of the home cell, issuing
// one cache read per cycle and a latency-aligned 1-based ID stream.
module particle_broadcast_ctrl
    import particle_broadcast_ctrl_pkg::*;
#(
    parameter int PARTICLE_ID_WIDTH = PBC_ID_WIDTH,
    parameter int RD_LATENCY        = PBC_RD_LATENCY
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [PARTICLE_ID_WIDTH-1:0] particle_num,
    input  logic                         particle_num_valid,
    input  logic                         stall,
    output logic                         rd_en,
    output logic [PARTICLE_ID_WIDTH-1:0] rd_addr,
    output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
    output logic                         ref_advance,
    output logic [PARTICLE_ID_WIDTH-1:0] particle_id,
    output logic                         particle_valid,
    output logic [PARTICLE_ID_WIDTH-1:0] particle_num_out,
    output logic                         busy,
    output logic                         phase_done
);

    localparam int W   = PARTICLE_ID_WIDTH;
    localparam int CW  = W + 1;
    localparam int DCW = $clog2(RD_LATENCY + 1);
    localparam logic [DCW-1:0] DRAIN_LAST  = DCW'(RD_LATENCY);
    localparam logic [DCW-1:0] DRAIN_FINAL = DCW'(RD_LATENCY - 1);

    state_t          r_state;
    logic [W-1:0]    r_num;
    logic [W-1:0]    r_ref;
    logic [CW-1:0]   r_nb;
    logic [CW-1:0]   r_idHold;
    logic [DCW-1:0]  r_drainCnt;
    logic            r_refAdvance;
    logic            r_phaseDone;

    logic            w_issue;
    logic            w_lastNb;
    logic            w_lastRef;
    logic [W-1:0]    w_dlyId;
    logic            w_dlyValid;
    logic [W-1:0]    w_idHoldSat;

    assign w_issue   = (r_state == ST_BROADCAST) && !stall;
    assign w_lastNb  = (r_nb == {1'b0, r_num});
    assign w_lastRef = (r_ref == r_num);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_num        <= '0;
            r_ref        <= '0;
            r_nb         <= '0;
            r_drainCnt   <= '0;
            r_refAdvance <= 1'b0;
            r_phaseDone  <= 1'b0;
        end else begin
            r_refAdvance <= 1'b0;
            r_phaseDone  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_WAIT_NUM;
                        r_num   <= '0;
                    end
                end
                ST_WAIT_NUM: begin
                    if (particle_num_valid) begin
                        r_num <= particle_num;
                        if (particle_num == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_BROADCAST;
                            r_ref   <= W'(1);
                            r_nb    <= CW'(1);
                        end
                    end
                end
                // Stall freezes the counters, so a wrap or final issue waits for the first free cycle.
                ST_BROADCAST: begin
                    if (!stall) begin
                        if (!w_lastNb) begin
                            r_nb <= r_nb + CW'(1);
                        end else if (!w_lastRef) begin
                            r_nb         <= CW'(1);
                            r_ref        <= r_ref + W'(1);
                            r_refAdvance <= 1'b1;
                        end else begin
                            r_nb       <= {1'b0, r_num} + CW'(1);
                            r_drainCnt <= '0;
                            r_state    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_drainCnt == DRAIN_LAST) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_drainCnt <= r_drainCnt + DCW'(1);
                    end
                end
                ST_DONE: begin
                    r_phaseDone <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    particle_id_delay #(
        .ID_W    (W),
        .LATENCY (RD_LATENCY)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_id    (r_nb[W-1:0]),
        .i_valid (w_issue),
        .o_id    (w_dlyId),
        .o_valid (w_dlyValid)
    );

    // Hold the last delivered ID so the done check never sees a spurious 0;
    // it is cleared on a new start and forced to num+1 right after the last valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idHold <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_idHold <= '0;
        end else if (r_state == ST_DRAIN && r_drainCnt == DRAIN_FINAL) begin
            r_idHold <= r_nb;
        end else if (w_dlyValid) begin
            r_idHold <= {1'b0, w_dlyId};
        end
    end

    assign w_idHoldSat = r_idHold[CW-1] ? {W{1'b1}} : r_idHold[W-1:0];

    assign rd_en            = w_issue;
    assign rd_addr          = (r_state == ST_BROADCAST) ? (r_nb[W-1:0] - W'(1)) : '0;
    assign ref_id           = r_ref;
    assign ref_advance      = r_refAdvance;
    assign particle_id      = w_dlyValid ? w_dlyId : w_idHoldSat;
    assign particle_valid   = w_dlyValid;
    assign particle_num_out = r_num;
    assign busy             = (r_state != ST_IDLE);
    assign phase_done       = r_phaseDone;

endmodule

// File: tb/tb_particle_broadcast_ctrl.sv
// Directed bench for particle_broadcast_ctrl: records per-cycle outputs and
// checks read sequences, latencies, stalls, resets and phase completion.
module tb_particle_broadcast_ctrl;

    localparam int W    = 7;
    localparam int L    = 3;
    localparam int HIST = 2048;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] particle_num;
    logic         particle_num_valid;
    logic         stall;
    logic         rd_en;
    logic [W-1:0] rd_addr;
    logic [W-1:0] ref_id;
    logic         ref_advance;
    logic [W-1:0] particle_id;
    logic         particle_valid;
    logic [W-1:0] particle_num_out;
    logic         busy;
    logic         phase_done;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    bit rdHist   [HIST];
    bit vHist    [HIST];
    bit advHist  [HIST];
    bit doneHist [HIST];
    int addrHist [HIST];
    int idHist   [HIST];

    particle_broadcast_ctrl #(
        .PARTICLE_ID_WIDTH (W),
        .RD_LATENCY        (L)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .particle_num       (particle_num),
        .particle_num_valid (particle_num_valid),
        .stall              (stall),
        .rd_en              (rd_en),
        .rd_addr            (rd_addr),
        .ref_id             (ref_id),
        .ref_advance        (ref_advance),
        .particle_id        (particle_id),
        .particle_valid     (particle_valid),
        .particle_num_out   (particle_num_out),
        .busy               (busy),
        .phase_done         (phase_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle record of the outputs, sampled mid-cycle.
    always @(negedge clk) begin
        if (cyc < HIST) begin
            rdHist[cyc]   = rd_en;
            vHist[cyc]    = particle_valid;
            advHist[cyc]  = ref_advance;
            doneHist[cyc] = phase_done;
            addrHist[cyc] = int'(rd_addr);
            idHist[cyc]   = int'(particle_id);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int n, input int waitCycles, output int vCyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < waitCycles; i++) begin
            checkOutput("wait_rd_en", rd_en, 0);
            checkOutput("wait_busy", busy, 1);
            tick();
        end
        particle_num       = W'(n);
        particle_num_valid = 1'b1;
        vCyc               = cyc;
        tick();
        particle_num_valid = 1'b0;
    endtask

    task automatic waitDone(input int bound, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (phase_done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) checkOutput({tag, "_timeout"}, 0, 1);
        repeat (3) tick();
    endtask

    task automatic analyze(input int fromC, input int toC,
                           output int nRd, output int firstRd, output int lastRd,
                           output int nV, output int firstV, output int lastV,
                           output int nAdv, output int nDone, output int doneC);
        nRd = 0; firstRd = -1; lastRd = -1;
        nV = 0; firstV = -1; lastV = -1;
        nAdv = 0; nDone = 0; doneC = -1;
        for (int c = fromC; c <= toC && c < HIST; c++) begin
            if (rdHist[c]) begin
                nRd++;
                if (firstRd < 0) firstRd = c;
                lastRd = c;
            end
            if (vHist[c]) begin
                nV++;
                if (firstV < 0) firstV = c;
                lastV = c;
            end
            if (advHist[c]) nAdv++;
            if (doneHist[c]) begin
                nDone++;
                doneC = c;
            end
        end
    endtask

    // Expected order: neighbour IDs 1..n repeated once per reference.
    task automatic checkSeq(input int fromC, input int toC, input int n, input string tag);
        int k = 0;
        int j = 0;
        for (int c = fromC; c <= toC && c < HIST; c++) begin
            if (rdHist[c]) begin
                checkOutput({tag, "_rd_addr"}, addrHist[c], k % n);
                k++;
            end
            if (vHist[c]) begin
                checkOutput({tag, "_particle_id"}, idHist[c], (j % n) + 1);
                j++;
            end
        end
    endtask

    initial begin
        int base, vCyc;
        int nRd, firstRd, lastRd, nV, firstV, lastV, nAdv, nDone, doneC;
        logic [19:0] pat;
        logic [19:0] obsRd;
        logic [19:0] obsV;
        int rds;

        rst_n = 1'b1; start = 1'b0; particle_num = '0; particle_num_valid = 1'b0; stall = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_outputs", {rd_en, rd_addr, ref_id, ref_advance, particle_id,
                    particle_valid, particle_num_out, busy, phase_done}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Empty cell.
        base = cyc;
        applyStimulus(0, 0, vCyc);
        waitDone(20, "num0");
        analyze(base, cyc - 1, nRd, firstRd, lastRd, nV, firstV, lastV, nAdv, nDone, doneC);
        checkOutput("num0_reads", nRd, 0);
        checkOutput("num0_done_count", nDone, 1);
        checkOutput("num0_done_cycle", doneC - vCyc, 2);
        checkOutput("num0_particle_id", particle_id, 0);
        checkOutput("num0_num_out", particle_num_out, 0);
        checkOutput("num0_busy_after", busy, 0);

        // num=3, no stall.
        base = cyc;
        applyStimulus(3, 0, vCyc);
        checkOutput("num3_busy", busy, 1);
        waitDone(60, "num3");
        analyze(base, cyc - 1, nRd, firstRd, lastRd, nV, firstV, lastV, nAdv, nDone, doneC);
        checkOutput("num3_reads", nRd, 9);
        checkOutput("num3_first_rd", firstRd - vCyc, 1);
        checkOutput("num3_contiguous", lastRd - firstRd, 8);
        checkOutput("num3_ref_adv", nAdv, 2);
        checkOutput("num3_valid_count", nV, 9);
        checkOutput("num3_valid_latency", firstV - firstRd, 3);
        checkOutput("num3_done_after_valid", doneC - lastV, 3);
        checkOutput("num3_done_count", nDone, 1);
        checkOutput("num3_final_id", particle_id, 4);
        checkOutput("num3_num_out", particle_num_out, 3);
        checkSeq(base, cyc - 1, 3, "num3");

        // num=4 with two 2-cycle stalls: at nb=2 and at the first reference wrap.
        base = cyc;
        applyStimulus(4, 0, vCyc);
        for (int i = 0; i < 20; i++) begin
            if (rd_addr == 1 && ref_id == 1) break;
            tick();
        end
        stall = 1'b1;
        tick();
        tick();
        stall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rd_addr == 3 && ref_id == 1) break;
            tick();
        end
        stall = 1'b1;
        tick();
        tick();
        stall = 1'b0;
        waitDone(80, "stall");
        analyze(base, cyc - 1, nRd, firstRd, lastRd, nV, firstV, lastV, nAdv, nDone, doneC);
        checkOutput("stall_reads", nRd, 16);
        checkOutput("stall_ref_adv", nAdv, 3);
        checkOutput("stall_done_count", nDone, 1);
        pat = 20'hFFF99;
        obsRd = '0;
        obsV  = '0;
        for (int k = 0; k < 20; k++) begin
            if (firstRd >= 0 && firstRd + L + k < HIST) begin
                obsRd[k] = rdHist[firstRd + k];
                obsV[k]  = vHist[firstRd + L + k];
            end
        end
        checkOutput("stall_rd_pattern", obsRd, pat);
        checkOutput("stall_valid_pattern", obsV, pat);
        checkOutput("stall_final_id", particle_id, 5);
        checkSeq(base, cyc - 1, 4, "stall");

        // Count arrives 5 cycles after start.
        base = cyc;
        applyStimulus(2, 5, vCyc);
        waitDone(40, "delayed");
        analyze(base, cyc - 1, nRd, firstRd, lastRd, nV, firstV, lastV, nAdv, nDone, doneC);
        checkOutput("delayed_first_rd", firstRd - vCyc, 1);
        checkOutput("delayed_reads", nRd, 4);
        checkOutput("delayed_done_count", nDone, 1);

        // Reset after 7 reads of a num=5 phase.
        base = cyc;
        applyStimulus(5, 0, vCyc);
        rds = 0;
        for (int i = 0; i < 50; i++) begin
            if (rd_en) rds++;
            if (rds == 7) break;
            tick();
        end
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_outputs", {rd_en, rd_addr, ref_id, ref_advance, particle_id,
                    particle_valid, particle_num_out, busy, phase_done}, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        analyze(base, cyc - 1, nRd, firstRd, lastRd, nV, firstV, lastV, nAdv, nDone, doneC);
        checkOutput("midreset_reads", nRd, 7);
        checkOutput("midreset_no_done", nDone, 0);
        base = cyc;
        applyStimulus(2, 0, vCyc);
        waitDone(40, "after_reset");
        analyze(base, cyc - 1, nRd, firstRd, lastRd, nV, firstV, lastV, nAdv, nDone, doneC);
        checkOutput("after_reset_reads", nRd, 4);
        checkOutput("after_reset_done_count", nDone, 1);
        checkOutput("after_reset_final_id", particle_id, 3);

        // Second start pulse during BROADCAST must be ignored.
        base = cyc;
        applyStimulus(3, 0, vCyc);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        waitDone(60, "restart");
        repeat (10) tick();
        analyze(base, cyc - 1, nRd, firstRd, lastRd, nV, firstV, lastV, nAdv, nDone, doneC);
        checkOutput("restart_reads", nRd, 9);
        checkOutput("restart_first_rd", firstRd - vCyc, 1);
        checkOutput("restart_contiguous", lastRd - firstRd, 8);
        checkOutput("restart_ref_adv", nAdv, 2);
        checkOutput("restart_done_count", nDone, 1);
        checkOutput("restart_done_after_valid", doneC - lastV, 3);
        checkOutput("restart_busy_after", busy, 0);
        checkSeq(base, cyc - 1, 3, "restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/particle_broadcast_ctrl.md
Name: particle_broadcast_ctrl

Overview:
- Sequencer directly upstream of the broadcast-completion check in the MD core.
- For every reference particle of the home cell, it sweeps all neighbour particle IDs and issues one particle-cache read per cycle.
- It emits the 1-based particle ID stream consumed by the "broadcast done" comparison, and that ID is latency-aligned with the cache read data.
- It also owns the reference-particle loop and signals completion of the whole cell phase.

Parameters:
- PARTICLE_ID_WIDTH, 7, width of particle IDs and counts. IDs are 1-based; 0 means "no particle / count unknown".
- RD_LATENCY, 3, particle-cache read latency in cycles. Must be ≥1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a cell phase; honoured only in IDLE
- particle_num  in  PARTICLE_ID_WIDTH  particle count of the home cell
- particle_num_valid  in  1  qualifies particle_num; sampled only in WAIT_NUM
- stall  in  1  back-pressure from the force pipeline; blocks issue
- rd_en  out  1  particle-cache read strobe
- rd_addr  out  PARTICLE_ID_WIDTH  cache address, equal to issued ID − 1
- ref_id  out  PARTICLE_ID_WIDTH  current reference particle ID
- ref_advance  out  1  one-cycle pulse when ref_id changes to the next reference
- particle_id  out  PARTICLE_ID_WIDTH  issued ID delayed by RD_LATENCY; feeds the done check
- particle_valid  out  1  particle_id and cache data are valid this cycle
- particle_num_out  out  PARTICLE_ID_WIDTH  latched count; 0 until latched
- busy  out  1  high in every state except IDLE
- phase_done  out  1  one-cycle pulse at the end of the phase

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - rd_en, ref_advance, particle_valid, busy and phase_done go to 0.
  - rd_addr, ref_id, particle_id and particle_num_out go to 0.
  - The delay line is cleared.
  - Reset asserted mid-phase aborts the phase with no phase_done.
- States: IDLE, WAIT_NUM, BROADCAST, DRAIN, DONE.
- IDLE:
  - start=1 moves to WAIT_NUM on the next edge.
  - start in any other state is ignored.
- WAIT_NUM: hold until particle_num_valid=1, then latch particle_num.
  - If the latched value is 0 (empty cell), go to DONE.
  - Otherwise go to BROADCAST with ref_id=1 and the neighbour counter nb=1.
- BROADCAST, each cycle with stall=0:
  - Assert rd_en with rd_addr=nb−1.
  - Push (nb, valid=1) into the delay line.
  - Counter update:
    - If nb<num: nb increments.
    - If nb==num and ref_id<num: nb returns to 1, ref_id increments and ref_advance pulses. There is no bubble between references.
    - If nb==num and ref_id==num: nb becomes num+1 and the state goes to DRAIN.
- BROADCAST, each cycle with stall=1:
  - rd_en=0 and the counters hold.
  - The delay line still shifts, with a valid=0 bubble.
- Delay line: a RD_LATENCY-deep shift register of {id, valid}.
  - particle_valid is the delayed valid.
  - particle_id updates only when the delayed valid=1, otherwise it holds. A downstream done check therefore never sees spurious 0s.
- DRAIN:
  - Wait RD_LATENCY cycles, ignoring stall, then go to DONE.
  - On the cycle after the final valid output, particle_id becomes num+1, so the downstream check (id > num, num ≠ 0) resolves true.
- DONE: phase_done=1 for one cycle, then IDLE.
- busy=1 from WAIT_NUM through DONE inclusive.
- Width rules:
  - Counters use PARTICLE_ID_WIDTH+1 bits internally so that num+1 cannot wrap. The maximum num is 2^W−1.
  - Outputs are truncated to W bits, except particle_id at num = 2^W−1, which saturates at that value. Spec forbids num = 2^W−1 at this boundary; the bench does not drive it.
- Read issue and latency:
  - Total reads per phase = num².
  - The first rd_en occurs 1 cycle after particle_num_valid is accepted.
  - particle_valid follows rd_en by exactly RD_LATENCY cycles.
- Simultaneous stall and a wrap or last-issue condition: stall wins, and the transition occurs on the first unstalled cycle.

Decomposition:
- Shared package:
  - State enum.
  - PARTICLE_ID_WIDTH default.
  - RD_LATENCY default.
- One natural sub-module: particle_id_delay, a parameterised RD_LATENCY-stage {id, valid} shift register with asynchronous active-low reset.

Test Plan:
- num=3, no stall: start, then valid with 3.
  - rd_addr sequence is 0,1,2 repeated 3 times: 9 rd_en cycles, contiguous.
  - ref_advance pulses exactly 2 times.
  - particle_valid is first seen 3 cycles after the first rd_en.
  - phase_done comes exactly 3 cycles after the last valid output.
- num=0: start, then valid with 0.
  - No rd_en at all.
  - phase_done occurs 1 cycle after entering DONE.
  - particle_id stays 0.
- num=4, stall high for 2 cycles at nb=2 and again at the ref wrap.
  - rd_addr sequence is unchanged and the total is 16 reads.
  - particle_valid shows exactly 2-cycle bubbles at the matching delayed positions.
- Delayed count: start, with particle_num_valid held low for 5 cycles.
  - rd_en=0 and busy=1 during the wait.
  - Issue begins 1 cycle after valid.
- Reset mid-phase: num=5, rst_n low after 7 reads.
  - All outputs are 0 immediately (asynchronous).
  - No phase_done.
  - A fresh start with num=2 completes with 4 reads.
- start pulsed again during BROADCAST (num=3).
  - Ignored; the sequence is identical to the first scenario.
  - A single phase_done.
